// File: rtl/hack_cpu_seq_if.sv
// Bus bundle for hack_cpu_seq: instruction fetch, data memory and ALU control/result signals.
// master = CPU side, slave = ROM/RAM/ALU environment side.
interface hack_cpu_seq_if #(
  parameter int unsigned PC_W = 15
) ();
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] addr_m;
  logic            rd_m;
  logic [15:0]     in_m;
  logic            in_m_valid;
  logic [15:0]     out_m;
  logic            write_m;
  logic            write_ack;
  logic [15:0]     alu_x;
  logic [15:0]     alu_y;
  logic            alu_zx;
  logic            alu_nx;
  logic            alu_zy;
  logic            alu_ny;
  logic            alu_f;
  logic            alu_no;
  logic [15:0]     alu_out;
  logic            alu_zr;
  logic            alu_ng;

  modport master (
    input  instr, instr_valid, in_m, in_m_valid, write_ack, alu_out, alu_zr, alu_ng,
    output instr_ready, pc, addr_m, rd_m, out_m, write_m,
           alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );

  modport slave (
    output instr, instr_valid, in_m, in_m_valid, write_ack, alu_out, alu_zr, alu_ng,
    input  instr_ready, pc, addr_m, rd_m, out_m, write_m,
           alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );
endinterface

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: fetch, optional M read, one-cycle EXEC on the external ALU,
// optional M write. Holds A, D, PC; all outputs are registered.
module hack_cpu_seq #(
  parameter int unsigned     PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  hack_cpu_seq_if.master bus
);

  typedef enum logic [1:0] {FETCH, READM, EXEC, WRITE} state_e;

  state_e          state_q, state_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [11:0]     ir_q, ir_d;
  logic [15:0]     m_q, m_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_m_q, addr_m_d;
  logic [15:0]     out_m_q, out_m_d;
  logic            rd_m_q, rd_m_d;
  logic            write_m_q, write_m_d;
  logic            instr_ready_q, instr_ready_d;
  logic [15:0]     alu_x_q, alu_x_d;
  logic [15:0]     alu_y_q, alu_y_d;
  logic [5:0]      ctrl_q, ctrl_d;
  logic [PC_W-1:0] pc_inc;
  logic            take;
  logic            unused_instr;

  assign pc_inc       = pc_q + PC_W'(1);
  assign unused_instr = &bus.instr[14:13];

  // ALU operands/controls are loaded on the edge entering EXEC so they are valid for exactly
  // that cycle, and fall back to zero by default everywhere else.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    d_d       = d_q;
    ir_d      = ir_q;
    m_d       = m_q;
    pc_d      = pc_q;
    addr_m_d  = addr_m_q;
    out_m_d   = out_m_q;
    rd_m_d    = rd_m_q;
    write_m_d = write_m_q;
    alu_x_d   = '0;
    alu_y_d   = '0;
    ctrl_d    = '0;
    take      = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          if (!bus.instr[15]) begin
            a_d  = {1'b0, bus.instr[14:0]};
            pc_d = pc_inc;
          end else begin
            ir_d = bus.instr[11:0];
            if (bus.instr[12]) begin
              state_d  = READM;
              addr_m_d = a_q[PC_W-1:0];
              rd_m_d   = 1'b1;
            end else begin
              state_d = EXEC;
              alu_x_d = d_q;
              alu_y_d = a_q;
              ctrl_d  = bus.instr[11:6];
            end
          end
        end
      end
      READM: begin
        if (bus.in_m_valid) begin
          m_d     = bus.in_m;
          rd_m_d  = 1'b0;
          state_d = EXEC;
          alu_x_d = d_q;
          alu_y_d = bus.in_m;
          ctrl_d  = ir_q[11:6];
        end
      end
      EXEC: begin
        take = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) |
               (ir_q[0] & ~bus.alu_zr & ~bus.alu_ng);
        if (ir_q[5]) a_d = bus.alu_out;
        if (ir_q[4]) d_d = bus.alu_out;
        // a_q here is still the pre-EXEC A, so jump target and write address use A_old
        pc_d = take ? a_q[PC_W-1:0] : pc_inc;
        if (ir_q[3]) begin
          out_m_d   = bus.alu_out;
          addr_m_d  = a_q[PC_W-1:0];
          write_m_d = 1'b1;
          state_d   = WRITE;
        end else begin
          state_d = FETCH;
        end
      end
      WRITE: begin
        if (bus.write_ack) begin
          write_m_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    instr_ready_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      a_q           <= '0;
      d_q           <= '0;
      ir_q          <= '0;
      m_q           <= '0;
      pc_q          <= RESET_PC;
      addr_m_q      <= '0;
      out_m_q       <= '0;
      rd_m_q        <= 1'b0;
      write_m_q     <= 1'b0;
      instr_ready_q <= 1'b1;
      alu_x_q       <= '0;
      alu_y_q       <= '0;
      ctrl_q        <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      d_q           <= d_d;
      ir_q          <= ir_d;
      m_q           <= m_d;
      pc_q          <= pc_d;
      addr_m_q      <= addr_m_d;
      out_m_q       <= out_m_d;
      rd_m_q        <= rd_m_d;
      write_m_q     <= write_m_d;
      instr_ready_q <= instr_ready_d;
      alu_x_q       <= alu_x_d;
      alu_y_q       <= alu_y_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.pc          = pc_q;
  assign bus.addr_m      = addr_m_q;
  assign bus.rd_m        = rd_m_q;
  assign bus.out_m       = out_m_q;
  assign bus.write_m     = write_m_q;
  assign bus.alu_x       = alu_x_q;
  assign bus.alu_y       = alu_y_q;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ctrl_q;

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Self-checking bench for hack_cpu_seq: behavioural ALU, ROM/RAM handshakes with programmable
// delay, and an architectural Hack model (A, D, PC, memory) predicting every observable.
module tb_hack_cpu_seq;
  localparam int unsigned PC_W = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hack_cpu_seq_if #(.PC_W(PC_W)) bus ();

  hack_cpu_seq #(.PC_W(PC_W), .RESET_PC(15'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [15:0] mA, mD;
  logic [14:0] mPC;
  logic [15:0] mem [0:32767];

  // Hack ALU: returns {ng, zr, out}
  function automatic logic [17:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return {o[15], (o == 16'h0), o};
  endfunction

  logic [17:0] alu_res;
  logic [5:0]  ctrl_obs;
  assign ctrl_obs = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
  assign alu_res  = alu_fn(bus.alu_x, bus.alu_y, ctrl_obs);
  assign bus.alu_out = alu_res[15:0];
  assign bus.alu_zr  = alu_res[16];
  assign bus.alu_ng  = alu_res[17];

  // Executes one instruction through all handshakes, checking each phase against the model.
  task automatic run_instr(input logic [15:0] ins, input int rd_wait, input int wr_cyc,
                           output int cyc, output int whigh);
    logic [15:0] y, res, a_old;
    logic [17:0] r;
    logic        take;
    cyc = 0;
    whigh = 0;
    assert_cnt++;
    if (bus.instr_ready !== 1'b1) begin
      fail_cnt++; $display("FAIL ready_pre: got %b exp 1", bus.instr_ready);
    end
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); cyc++;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = 16'($urandom);
    if (!ins[15]) begin
      mA  = {1'b0, ins[14:0]};
      mPC = mPC + 15'd1;
    end else begin
      a_old = mA;
      if (ins[12]) begin
        assert_cnt++;
        if (bus.rd_m !== 1'b1 || bus.addr_m !== mA[14:0]) begin
          fail_cnt++; $display("FAIL readm: rd_m=%b addr=%h exp rd_m=1 addr=%h", bus.rd_m, bus.addr_m, mA[14:0]);
        end
        for (int i = 0; i < rd_wait; i++) begin
          @(posedge clk); cyc++;
          @(negedge clk);
        end
        bus.in_m = mem[mA[14:0]];
        bus.in_m_valid = 1'b1;
        @(posedge clk); cyc++;
        @(negedge clk);
        bus.in_m_valid = 1'b0;
        bus.in_m = 16'($urandom);
        y = mem[mA[14:0]];
      end else begin
        y = mA;
      end
      assert_cnt++;
      if (bus.alu_x !== mD || bus.alu_y !== y || ctrl_obs !== ins[11:6] || bus.instr_ready !== 1'b0) begin
        fail_cnt++;
        $display("FAIL exec: x=%h y=%h ctrl=%b rdy=%b exp x=%h y=%h ctrl=%b rdy=0",
                 bus.alu_x, bus.alu_y, ctrl_obs, bus.instr_ready, mD, y, ins[11:6]);
      end
      r    = alu_fn(mD, y, ins[11:6]);
      res  = r[15:0];
      take = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0) || (ins[0] && $signed(res) > 0);
      if (ins[5]) mA = res;
      if (ins[4]) mD = res;
      mPC = take ? a_old[14:0] : mPC + 15'd1;
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ins[3]) begin
        assert_cnt++;
        if (bus.write_m !== 1'b1 || bus.addr_m !== a_old[14:0] || bus.out_m !== res) begin
          fail_cnt++;
          $display("FAIL write: wm=%b addr=%h data=%h exp wm=1 addr=%h data=%h",
                   bus.write_m, bus.addr_m, bus.out_m, a_old[14:0], res);
        end
        for (int i = 0; i < wr_cyc; i++) begin
          if (bus.write_m === 1'b1) whigh++;
          if (i == wr_cyc - 1) bus.write_ack = 1'b1;
          @(posedge clk); cyc++;
          @(negedge clk);
          bus.write_ack = 1'b0;
        end
        mem[a_old[14:0]] = res;
      end
    end
    assert_cnt++;
    if (bus.instr_ready !== 1'b1 || bus.pc !== mPC || bus.rd_m !== 1'b0 || bus.write_m !== 1'b0 ||
        ctrl_obs !== 6'b0 || bus.alu_x !== 16'h0 || bus.alu_y !== 16'h0) begin
      fail_cnt++;
      $display("FAIL post: rdy=%b pc=%h rd=%b wm=%b ctrl=%b x=%h y=%h exp rdy=1 pc=%h rd=0 wm=0 ctrl=0 x=0 y=0",
               bus.instr_ready, bus.pc, bus.rd_m, bus.write_m, ctrl_obs, bus.alu_x, bus.alu_y, mPC);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    assert_cnt++;
    if (bus.instr_ready !== 1'b1 || bus.pc !== 15'd0 || bus.rd_m !== 1'b0 || bus.write_m !== 1'b0 ||
        bus.addr_m !== 15'd0 || bus.out_m !== 16'h0 || bus.alu_x !== 16'h0 || bus.alu_y !== 16'h0 ||
        ctrl_obs !== 6'b0) begin
      fail_cnt++;
      $display("FAIL reset: rdy=%b pc=%h rd=%b wm=%b addr=%h out=%h x=%h y=%h ctrl=%b exp 1/0/0/0/0/0/0/0/0",
               bus.instr_ready, bus.pc, bus.rd_m, bus.write_m, bus.addr_m, bus.out_m,
               bus.alu_x, bus.alu_y, ctrl_obs);
    end
    rst_n = 1'b1;
    mA = 16'h0; mD = 16'h0; mPC = 15'd0;
  endtask

  task automatic test_a_instr();
    int cyc, wh;
    run_instr(16'h0005, 0, 1, cyc, wh);
    assert_cnt++;
    if (cyc != 1 || bus.pc !== 15'd1) begin
      fail_cnt++; $display("FAIL a_instr: cyc=%0d pc=%h exp cyc=1 pc=1", cyc, bus.pc);
    end
  endtask

  task automatic test_c_instr();
    int cyc, wh;
    run_instr(16'hEC10, 0, 1, cyc, wh);
    assert_cnt++;
    if (cyc != 2 || bus.pc !== 15'd2 || mD !== 16'd5) begin
      fail_cnt++; $display("FAIL c_instr: cyc=%0d pc=%h exp cyc=2 pc=2", cyc, bus.pc);
    end
  endtask

  task automatic test_write();
    int cyc, wh;
    run_instr(16'd100, 0, 1, cyc, wh);
    run_instr(16'hE7C8, 0, 3, cyc, wh);
    assert_cnt++;
    if (wh != 3 || cyc != 5 || bus.addr_m !== 15'd100 || bus.out_m !== 16'd6 || bus.pc !== 15'd4) begin
      fail_cnt++;
      $display("FAIL write_late_ack: whigh=%0d cyc=%0d addr=%h out=%h pc=%h exp 3/5/064/0006/0004",
               wh, cyc, bus.addr_m, bus.out_m, bus.pc);
    end
  endtask

  task automatic test_jump();
    int cyc, wh;
    logic [14:0] pcs [0:2];
    run_instr(16'd16, 0, 1, cyc, wh);
    run_instr(16'hEA87, 0, 1, cyc, wh);
    pcs[0] = bus.pc;
    run_instr(16'hEA90, 0, 1, cyc, wh);
    run_instr(16'd40, 0, 1, cyc, wh);
    run_instr(16'hE302, 0, 1, cyc, wh);
    pcs[1] = bus.pc;
    run_instr(16'd3, 0, 1, cyc, wh);
    run_instr(16'hEC10, 0, 1, cyc, wh);
    run_instr(16'd40, 0, 1, cyc, wh);
    run_instr(16'hE302, 0, 1, cyc, wh);
    pcs[2] = bus.pc;
    assert_cnt++;
    if (pcs[0] !== 15'd16 || pcs[1] !== 15'd40 || pcs[2] !== 15'd44) begin
      fail_cnt++; $display("FAIL jump: pcs=%0d,%0d,%0d exp 16,40,44", pcs[0], pcs[1], pcs[2]);
    end
  endtask

  task automatic test_readm();
    int cyc, wh;
    mem[15'h20] = 16'h1234;
    run_instr(16'h0020, 0, 1, cyc, wh);
    run_instr(16'hFC10, 2, 1, cyc, wh);
    assert_cnt++;
    if (cyc != 5) begin
      fail_cnt++; $display("FAIL readm_latency: cyc=%0d exp 5", cyc);
    end
    mem[15'h21] = 16'h0;
    run_instr(16'h0021, 0, 1, cyc, wh);
    run_instr(16'hE308, 0, 1, cyc, wh);
    assert_cnt++;
    if (bus.out_m !== 16'h1234 || bus.addr_m !== 15'h21) begin
      fail_cnt++; $display("FAIL readm_d: out=%h addr=%h exp 1234/0021", bus.out_m, bus.addr_m);
    end
  endtask

  task automatic test_idle();
    logic [14:0] pc0;
    pc0 = bus.pc;
    bus.write_ack = 1'b1;
    bus.in_m_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.write_ack = 1'b0;
    bus.in_m_valid = 1'b0;
    assert_cnt++;
    if (bus.pc !== pc0 || bus.instr_ready !== 1'b1 || bus.write_m !== 1'b0 || bus.rd_m !== 1'b0) begin
      fail_cnt++;
      $display("FAIL idle: pc=%h rdy=%b wm=%b rd=%b exp pc=%h rdy=1 wm=0 rd=0",
               bus.pc, bus.instr_ready, bus.write_m, bus.rd_m, pc0);
    end
  endtask

  task automatic test_reset_in_write();
    int cyc, wh;
    run_instr(16'h0050, 0, 1, cyc, wh);
    bus.instr = 16'hE308;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    assert_cnt++;
    if (bus.write_m !== 1'b1) begin
      fail_cnt++; $display("FAIL pre_reset_write: wm=%b exp 1", bus.write_m);
    end
    #2 rst_n = 1'b0;
    #1;
    assert_cnt++;
    if (bus.write_m !== 1'b0 || bus.pc !== 15'd0 || bus.instr_ready !== 1'b1 || bus.addr_m !== 15'd0) begin
      fail_cnt++;
      $display("FAIL async_reset: wm=%b pc=%h rdy=%b addr=%h exp 0/0000/1/0000",
               bus.write_m, bus.pc, bus.instr_ready, bus.addr_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mA = 16'h0; mD = 16'h0; mPC = 15'd0;
    run_instr(16'hE090, 0, 1, cyc, wh);
    run_instr(16'h7FFF, 0, 1, cyc, wh);
    run_instr(16'hEA87, 0, 1, cyc, wh);
    run_instr(16'h0001, 0, 1, cyc, wh);
    assert_cnt++;
    if (bus.pc !== 15'd0) begin
      fail_cnt++; $display("FAIL pc_wrap: pc=%h exp 0000", bus.pc);
    end
  endtask

  task automatic test_random();
    int cyc, wh, rw, wc, exp_cyc;
    logic [15:0] ins;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else                           ins = {3'b111, 13'($urandom)};
      rw = $urandom_range(0, 3);
      wc = $urandom_range(1, 3);
      run_instr(ins, rw, wc, cyc, wh);
      if (!ins[15]) exp_cyc = 1;
      else exp_cyc = 2 + (ins[12] ? rw + 1 : 0) + (ins[3] ? wc : 0);
      assert_cnt++;
      if (cyc != exp_cyc || (ins[15] && ins[3] && wh != wc)) begin
        fail_cnt++;
        $display("FAIL random_latency: ins=%h cyc=%0d whigh=%0d exp cyc=%0d whigh=%0d", ins, cyc, wh, exp_cyc, wc);
      end
    end
  endtask

  initial begin
    bus.instr = 16'h0;
    bus.instr_valid = 1'b0;
    bus.in_m = 16'h0;
    bus.in_m_valid = 1'b0;
    bus.write_ack = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    test_reset();
    test_a_instr();
    test_c_instr();
    test_write();
    test_jump();
    test_readm();
    test_idle();
    test_reset_in_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
